// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// The optional byte-enable store port is built in with DMEM_RESPONDER_BYTE_EN.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int WORD_W    = 32;
    localparam int LAT_W     = 4;
    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = WORD_W / BYTE_W;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0]    old_word,
        input logic [WORD_W-1:0]    new_word,
        input logic [NUM_BYTES-1:0] be
    );
        logic [WORD_W-1:0] result;
        result = old_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (be[i]) begin
                result[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with byte-lane writes and a registered read port.
// Storage is never reset; only the read-data register is.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic                 clr,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [WORD_W-1:0]    wdata,
    input  logic [NUM_BYTES-1:0] be,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] rdata_d;
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= merge_bytes(mem[addr], wdata, be);
        end
    end

    // Read data holds between responses; stores and faulted accesses zero it.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = mem[addr];
        end else if (clr) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store responder: one request at a time, LATENCY wait cycles, stall back to the pipeline.
// Define DMEM_RESPONDER_BYTE_EN to add the req_be byte-enable store port.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
`ifdef DMEM_RESPONDER_BYTE_EN
    input  logic [3:0]        req_be,
`endif
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              stall
);

    state_e                   state_q, state_d;
    logic [LAT_W-1:0]         cnt_q, cnt_d;
    logic                     write_q, write_d;
    logic                     mis_q, mis_d;
    logic                     err_q, err_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic [WORD_W-1:0]        wdata_q, wdata_d;
    logic [NUM_BYTES-1:0]     be_q, be_d;
    logic [NUM_BYTES-1:0]     in_be;
    logic                     enter_resp;
    logic                     arr_we, arr_rd, arr_clr;
    logic                     unused_addr;

`ifdef DMEM_RESPONDER_BYTE_EN
    assign in_be = req_be;
`else
    assign in_be = '1;
`endif

    assign unused_addr = ^{req_addr[31:ADDR_W+2]};

    // The *_d request fields always describe the access that completes when
    // enter_resp is set, whether it was just accepted (LATENCY=0) or latched.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        mis_d      = mis_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    mis_d   = (req_addr[1:0] != 2'b00);
                    idx_d   = req_addr[ADDR_W+1:2];
                    wdata_d = req_wdata;
                    be_d    = in_be;
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d   = LAT_W'(LATENCY - 1);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        arr_we  = enter_resp & write_d & ~mis_d & ~reset;
        arr_rd  = enter_resp & ~write_d & ~mis_d & ~reset;
        arr_clr = enter_resp & (write_d | mis_d);
        err_d   = enter_resp ? mis_d : err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .wr_en (arr_we),
        .rd_en (arr_rd),
        .clr   (arr_clr),
        .addr  (idx_d),
        .wdata (wdata_d),
        .be    (be_d),
        .rdata (rsp_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = err_q;
    assign stall     = ((state_q == IDLE) & req_valid) | (state_q == BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance.
// Byte-enable stores are exercised when DMEM_RESPONDER_BYTE_EN is defined.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, rsp_valid, rsp_err, stall;
    logic [31:0] rsp_rdata;

    logic        req0_valid, req0_write;
    logic [31:0] req0_addr, req0_wdata;
    logic [3:0]  req0_be;
    logic        req0_ready, rsp0_valid, rsp0_err, stall0;
    logic [31:0] rsp0_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef DMEM_RESPONDER_BYTE_EN
        .req_be    (req_be),
`endif
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .stall     (stall)
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req0_valid),
        .req_write (req0_write),
        .req_addr  (req0_addr),
        .req_wdata (req0_wdata),
`ifdef DMEM_RESPONDER_BYTE_EN
        .req_be    (req0_be),
`endif
        .req_ready (req0_ready),
        .rsp_valid (rsp0_valid),
        .rsp_rdata (rsp0_rdata),
        .rsp_err   (rsp0_err),
        .stall     (stall0)
    );

`ifndef DMEM_RESPONDER_BYTE_EN
    logic unused_be;
    assign unused_be = ^{req_be, req0_be};
`endif

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on the LATENCY=2 instance, held valid until its response.
    task automatic applyStimulus(input string tag, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        #1;
        checkOutput({tag, " ready_idle"}, 32'(req_ready), 32'd1);
        checkOutput({tag, " stall_req"}, 32'(stall), 32'd1);
        @(posedge clk); #1;
        n = 1;
        while (!rsp_valid && n < 20) begin
            checkOutput({tag, " stall_busy"}, 32'(stall), 32'd1);
            checkOutput({tag, " ready_busy"}, 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        #1;
        checkOutput({tag, " latency"}, 32'(n), 32'd3);
        checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({tag, " stall_resp"}, 32'(stall), 32'd0);
        checkOutput({tag, " ready_resp"}, 32'(req_ready), 32'd0);
        checkOutput({tag, " rdata"}, rsp_rdata, exp_rdata);
        checkOutput({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        @(posedge clk); #1;
        checkOutput({tag, " rsp_pulse"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, " ready_after"}, 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs0 [4];

    initial begin
        int hits;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = 4'hF;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0; req0_be = 4'hF;

        #2 reset = 1'b1;
        #1;
        checkOutput("rst ready", 32'(req_ready), 32'd1);
        checkOutput("rst stall", 32'(stall), 32'd0);
        checkOutput("rst rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst rdata", rsp_rdata, 32'd0);
        checkOutput("rst err", 32'(rsp_err), 32'd0);
        checkOutput("rst ready0", 32'(req0_ready), 32'd1);
        @(posedge clk); #2 reset = 1'b0;

        applyStimulus("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        applyStimulus("ld10", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
        applyStimulus("st13_mis", 1'b1, 32'h13, 32'hAAAAAAAA, 4'hF, 32'h0, 1'b1);
        applyStimulus("ld10_again", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
        applyStimulus("ld1010_wrap", 1'b0, 32'h1010, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
        applyStimulus("st20", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        applyStimulus("ld10_pre", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

        // Store accepted, then reset lands mid-cycle while it waits in BUSY.
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        checkOutput("rstbusy ready", 32'(req_ready), 32'd1);
        checkOutput("rstbusy stall", 32'(stall), 32'd0);
        checkOutput("rstbusy rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rstbusy rdata", rsp_rdata, 32'd0);
        @(posedge clk); #2 reset = 1'b0;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) hits++;
        end
        checkOutput("rstbusy no_rsp", 32'(hits), 32'd0);
        applyStimulus("ld20_old", 1'b0, 32'h20, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);

`ifdef DMEM_RESPONDER_BYTE_EN
        applyStimulus("be_fill", 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0);
        applyStimulus("be_st", 1'b1, 32'h20, 32'h00000000, 4'b0101, 32'h0, 1'b0);
        applyStimulus("be_ld", 1'b0, 32'h20, 32'h0, 4'h0, 32'hFF00FF00, 1'b0);
`endif

        // LATENCY=0: requests held valid back to back, one accept every two cycles.
        vecs0[0] = '{1'b1, 32'h0, 32'h11111111, 32'h0};
        vecs0[1] = '{1'b1, 32'h4, 32'h22222222, 32'h0};
        vecs0[2] = '{1'b0, 32'h0, 32'h0, 32'h11111111};
        vecs0[3] = '{1'b0, 32'h4, 32'h0, 32'h22222222};
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1;
            req0_write = vecs0[i].wr;
            req0_addr  = vecs0[i].addr;
            req0_wdata = vecs0[i].wdata;
            #1;
            checkOutput($sformatf("l0[%0d] ready", i), 32'(req0_ready), 32'd1);
            checkOutput($sformatf("l0[%0d] stall", i), 32'(stall0), 32'd1);
            checkOutput($sformatf("l0[%0d] idle_rsp", i), 32'(rsp0_valid), 32'd0);
            @(posedge clk); #1;
            checkOutput($sformatf("l0[%0d] rsp_valid", i), 32'(rsp0_valid), 32'd1);
            checkOutput($sformatf("l0[%0d] ready_resp", i), 32'(req0_ready), 32'd0);
            checkOutput($sformatf("l0[%0d] stall_resp", i), 32'(stall0), 32'd0);
            checkOutput($sformatf("l0[%0d] rdata", i), rsp0_rdata, vecs0[i].exp);
            checkOutput($sformatf("l0[%0d] err", i), 32'(rsp0_err), 32'd0);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
